// File: rtl/cpu_regdump_pkg.sv
// rtl/cpu_regdump_pkg.sv - shared register-file constants and dump FSM state type
package cpu_regdump_pkg;

  localparam int NUM_REGS  = 32;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_regdump.sv
// rtl/cpu_regdump.sv - walks a register index range and streams each word out
// Optional even-parity output enabled by CPU_REGDUMP_PARITY_EN.
module cpu_regdump
  import cpu_regdump_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_reg,
  input  logic [ADDR_W-1:0]    last_reg,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_W-1:0]    out_index,
  output logic                 out_last,
  output logic                 busy,
`ifdef CPU_REGDUMP_PARITY_EN
  output logic                 out_parity,
`endif
  output logic                 done
);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cur_q, cur_d;
  logic [ADDR_W-1:0]      stop_q, stop_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]      index_q, index_d;
  logic                   last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      stop_q  <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_reg;
          stop_d  = last_reg;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rd_data;
        index_d = cur_q;
        last_d  = (cur_q == stop_q);
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            // ADDR_W-bit add wraps NUM_REGS-1 back to 0
            cur_d   = cur_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cur only changes on edges entering READ, so it doubles as the read address
  assign rd_addr   = cur_q;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef CPU_REGDUMP_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (state_q == READ) begin
      parity_q <= ^rd_data;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_cpu_regdump.sv
// tb/tb_cpu_regdump.sv - directed bench for cpu_regdump with a queue-based model
// Build with CPU_REGDUMP_PARITY_EN to also cover out_parity.
module tb_cpu_regdump;
  import cpu_regdump_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    first_reg = '0;
  logic [ADDR_W-1:0]    last_reg = '0;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WORD_SIZE-1:0] out_data;
  logic [ADDR_W-1:0]    out_index;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 par;

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  cpu_regdump dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy),
`ifdef CPU_REGDUMP_PARITY_EN
    .out_parity(par),
`endif
    .done(done)
  );
`ifndef CPU_REGDUMP_PARITY_EN
  assign par = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]    idx;
    logic [WORD_SIZE-1:0] data;
    logic                 last;
    logic                 par;
    int                   cyc;
  } word_t;

  word_t exp_q[$];
  word_t log_q[$];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted start expands into its word list; outputs are checked every cycle.
  logic  m_reset = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_stall = 1'b0;
  logic  nb, nd;
  word_t mw, aw;
  int    mn, mi;

  always @(negedge clk) begin
    if (m_reset) begin
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_index", out_index, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_parity", par, 0);
    end
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (done) done_cnt++;
    if (m_stall) check("valid_held", out_valid, 1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        mw = exp_q[0];
        check("word_data", out_data, mw.data);
        check("word_index", out_index, mw.idx);
        check("word_last", out_last, mw.last);
`ifdef CPU_REGDUMP_PARITY_EN
        check("word_parity", par, mw.par);
`endif
      end
    end
    if (!rst) begin
      m_reset = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_stall = 1'b0;
      exp_q.delete();
    end else begin
      m_reset = 1'b0;
      nd = 1'b0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        mw = exp_q.pop_front();
        nd = mw.last;
        aw.idx = out_index; aw.data = out_data; aw.last = out_last; aw.par = par; aw.cyc = cyc;
        log_q.push_back(aw);
      end
      nb = m_busy;
      if (m_done) begin
        nb = 1'b0;
      end else if (!m_busy && start) begin
        nb = 1'b1;
        mn = ((int'(last_reg) - int'(first_reg) + NUM_REGS) % NUM_REGS) + 1;
        for (mi = 0; mi < mn; mi++) begin
          mw.idx  = ADDR_W'((int'(first_reg) + mi) % NUM_REGS);
          mw.data = regs[mw.idx];
          mw.last = (mi == mn - 1);
          mw.par  = ^regs[mw.idx];
          mw.cyc  = 0;
          exp_q.push_back(mw);
        end
      end
      m_stall = out_valid && !out_ready;
      m_busy  = nb;
      m_done  = nd;
    end
  end

  task automatic go(input int f, input int l);
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (!(done_cnt > d0 && !busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, (done_cnt > d0 && !busy), 1);
  endtask

  initial begin
    int d0;
    int n;
    int wrap_idx[4];
    logic [WORD_SIZE-1:0] sd;
    logic [ADDR_W-1:0] si;
    wrap_idx = '{30, 31, 0, 1};
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;

    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single-word dump with latency check
    regs[0] = 32'hDEADBEEF;
    out_ready = 1'b1;
    log_q.delete();
    d0 = done_cnt;
    go(0, 0);
    check("lat_busy", busy, 1);
    check("lat_valid_early", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    wait_done("single", 20);
    check("single_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("single_data", log_q[0].data, 32'hDEADBEEF);
      check("single_index", log_q[0].idx, 0);
      check("single_last", log_q[0].last, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("single_done_once", done_cnt - d0, 1);

    // Full sweep 0..31 with out_ready held high
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h100 + i;
    log_q.delete();
    go(0, 31);
    wait_done("sweep", 200);
    check("sweep_count", log_q.size(), 32);
    for (int k = 0; k < log_q.size(); k++) begin
      check("sweep_data", log_q[k].data, 32'h100 + k);
      check("sweep_index", log_q[k].idx, k);
      check("sweep_last", log_q[k].last, (k == 31));
      if (k > 0) check("sweep_spacing", log_q[k].cyc - log_q[k-1].cyc, 2);
    end

    // Wrapping range 30..1
    log_q.delete();
    go(30, 1);
    wait_done("wrap", 40);
    check("wrap_count", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      check("wrap_index", log_q[k].idx, wrap_idx[k]);
      check("wrap_last", log_q[k].last, (k == 3));
    end

    // Backpressure on word 2 with an ignored start during the stall
    log_q.delete();
    go(8, 11);
    n = 0;
    while (!(out_valid && log_q.size() == 1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_word2", (out_valid && log_q.size() == 1), 1);
    out_ready = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    start = 1'b1;
    sd = out_data;
    si = out_index;
    check("bp_word2_index", si, 9);
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("bp_valid_stable", out_valid, 1);
      check("bp_data_stable", out_data, sd);
      check("bp_index_stable", out_index, si);
    end
    out_ready = 1'b1;
    wait_done("bp", 40);
    check("bp_count", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      check("bp_index", log_q[k].idx, 8 + k);
      check("bp_data", log_q[k].data, 32'h108 + k);
    end

    // Reset while holding a word
    out_ready = 1'b0;
    go(0, 31);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reach_hold", out_valid, 1);
    d0 = done_cnt;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt - d0, 0);
    regs[4] = 32'hCAFE0004;
    out_ready = 1'b1;
    log_q.delete();
    go(4, 4);
    wait_done("after_rst", 20);
    check("after_rst_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("after_rst_data", log_q[0].data, 32'hCAFE0004);
      check("after_rst_index", log_q[0].idx, 4);
    end

`ifdef CPU_REGDUMP_PARITY_EN
    regs[5] = 32'h00000007;
    regs[6] = 32'h00000003;
    log_q.delete();
    go(5, 6);
    wait_done("parity", 20);
    check("parity_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("parity_reg5", log_q[0].par, 1);
      check("parity_reg6", log_q[1].par, 0);
    end
`endif

    check("model_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_regdump.md
# cpu_regdump

Debug read-out engine for the CPU register file. On a start pulse it walks a contiguous range of register indices and drives the register file's combinational read-address port one index at a time. Each returned word is captured and streamed out over a valid/ready handshake toward the debug/trace path. It is the reader counterpart to the register-file write port and does not disturb normal pipeline reads.

## Interface
- `NUM_REGS`, 32, number of architectural registers (power of two).
- `WORD_SIZE`, 32, register width in bits.
- `ADDR_W`, 5, index width; log2(NUM_REGS).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- `start`  in  1  request a dump; sampled only in IDLE.
- `first_reg`  in  ADDR_W  first index of the range; latched with `start`.
- `last_reg`  in  ADDR_W  last index of the range; latched with `start`.
- `rd_addr`  out  ADDR_W  read-address to the register file.
- `rd_data`  in  WORD_SIZE  combinational read data for `rd_addr`, same cycle.
- `out_valid`  out  1  `out_data`/`out_index`/`out_last` valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_data`  out  WORD_SIZE  captured register value.
- `out_index`  out  ADDR_W  register index of `out_data`.
- `out_last`  out  1  high with the final word of the range.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: when `start`=1, latch `first_reg`→`cur` and `last_reg`→`stop`, then go to READ. Otherwise stay in IDLE.
- READ: `rd_addr`=`cur`. Capture `rd_data`→`out_data` and `cur`→`out_index`. Set `out_last`=(`cur`==`stop`). Go to HOLD.
- HOLD: `out_valid`=1; output registers are held stable.
  - On handshake with `out_last`=1, go to DONE.
  - On handshake with `out_last`=0, set `cur`=`cur`+1 mod NUM_REGS and go to READ.
  - Without a handshake, stay in HOLD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Range rule: word count = ((`last_reg` − `first_reg`) mod NUM_REGS) + 1.
  - `first_reg` > `last_reg` wraps through NUM_REGS−1 to 0. Example: 30→1 yields 30, 31, 0, 1.
  - `first_reg` == `last_reg` yields exactly one word.
- `start` while `busy` is ignored; the latched range is unchanged.
- Concurrent register-file writes are allowed. The dump is not atomic: each word reflects the register contents during its READ cycle.
- `rd_addr` in IDLE/HOLD/DONE holds its last value and has no meaning.

## Timing
- Reset values: state=IDLE; `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; `out_data`=0, `out_index`=0, `rd_addr`=0.
- Reset mid-dump returns to IDLE on the next edge. `out_valid` drops in the same edge and no `done` is issued.
- Latency: `start` sampled at edge 0 → READ in cycle 1 → `out_valid`=1 from edge 2.
- Throughput: with `out_ready` held high, one word every 2 cycles.
- `done` is asserted in the cycle after the final handshake.
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.
- No combinational path from `out_ready` to `out_valid` or to the data outputs.
- Once `out_valid` rises it stays high, with stable payload, until the handshake.

## Configuration
- Macro: `CPU_REGDUMP_PARITY_EN`.
- When defined, adds port `out_parity` (out, 1).
  - Value is even parity of `out_data`: XOR of all bits, so data plus parity has an even number of ones.
  - Registered in READ together with `out_data`; reset value 0.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package holds `NUM_REGS`, `WORD_SIZE`, `ADDR_W` and the state enum typedef (IDLE/READ/HOLD/DONE). The register file uses the same constants from this package.
- Single module, with no sub-module: the FSM, the `cur`/`stop` counters and the output register are all inline.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → all outputs 0 and `busy`=0. Release, then `start` 0→0 with reg0=0xDEADBEEF → one word {0xDEADBEEF, index 0, last=1}, then `done` pulses exactly once.
- Full sweep: preload reg i=0x100+i, `start` 0→31, `out_ready`=1 → 32 words 0x100..0x11F, indices 0..31, `out_last` only on 31, words spaced 2 cycles apart.
- Wrap: `start` 30→1 → indices 30, 31, 0, 1 in that order; `out_last` on index 1; `done` one cycle after the 4th handshake.
- Backpressure: `out_ready` low for 5 cycles during word 2 → `out_valid` and payload stable across all 5 cycles, no word lost or duplicated. A `start` pulse during the stall is ignored.
- Mid-dump reset: `rst`=0 while in HOLD → next cycle `out_valid`=0, `busy`=0, no `done`. A new `start` 4→4 then dumps reg4 normally.
- Parity (with `CPU_REGDUMP_PARITY_EN`): reg5=0x00000007 → `out_parity`=1; reg6=0x00000003 → `out_parity`=0.
